// File: rtl/onchip_mem_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one single-port on-chip memory.
// The grant is combinational: a granted request is accepted in the same cycle,
// and read data comes back one cycle later on the granted requester's
// readdatavalid. Contention is resolved round-robin or by fixed priority, and
// each winner may hold the memory for a bounded burst of consecutive beats.
//
// Handshake: a requester's transfer is accepted in any cycle where it drives
// read or write high and sees waitrequest low; it must keep the request
// stable while waitrequest is high. Each accepted read produces exactly one
// readdatavalid pulse on the following cycle, in acceptance order.
module onchip_mem_arbiter #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MAX_BURST     = 8,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_debugaccess,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_debugaccess,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_debugaccess,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic             req0, req1;
    logic             owner;      // id granted most recently
    logic             rr_ptr;     // id preferred on the next fresh contention
    logic [CNT_W-1:0] hold_cnt;   // consecutive grants to owner; 0 = idle last cycle
    logic             rd_pend;    // a read was accepted last cycle
    logic             rd_id;      // which requester that read belongs to
    logic             gnt_any;
    logic             gnt_id;
    logic             gnt_read;
    logic             gnt_write;
    logic             sel1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant decision: burst hold first, then forced switch at the burst limit,
    // otherwise round-robin pointer or fixed priority. Nothing granted in reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt_any = 1'b1;
                if (hold_cnt != '0 && hold_cnt < MAX_CNT)
                    gnt_id = owner;
                else if (hold_cnt == MAX_CNT)
                    gnt_id = ~owner;
                else
                    gnt_id = (PRIORITY_MODE != 0) ? 1'b0 : rr_ptr;
            end else if (req0) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign sel1      = gnt_any & gnt_id;
    assign gnt_write = gnt_id ? m1_write : m0_write;
    assign gnt_read  = gnt_id ? m1_read  : m0_read;

    // Arbitration state and the one-deep read-return tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
            owner    <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            // A request with both read and write set is a write with no return.
            rd_pend <= gnt_any & gnt_read & ~gnt_write;
            if (gnt_any) begin
                rd_id  <= gnt_id;
                owner  <= gnt_id;
                rr_ptr <= ~gnt_id;
                if (hold_cnt != '0 && owner == gnt_id)
                    hold_cnt <= (hold_cnt == MAX_CNT) ? MAX_CNT : hold_cnt + 1'b1;
                else
                    hold_cnt <= CNT_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign m0_waitrequest   = ~(gnt_any & ~gnt_id);
    assign m1_waitrequest   = ~(gnt_any &  gnt_id);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend & ~rd_id;
    assign m1_readdatavalid = rd_pend &  rd_id;

    assign mem_address     = sel1 ? m1_address     : m0_address;
    assign mem_byteenable  = sel1 ? m1_byteenable  : m0_byteenable;
    assign mem_writedata   = sel1 ? m1_writedata   : m0_writedata;
    assign mem_debugaccess = sel1 ? m1_debugaccess : m0_debugaccess;
    assign mem_chipselect  = gnt_any;
    assign mem_write       = gnt_any & gnt_write;
    assign mem_clken       = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: one round-robin and one fixed-priority
// instance share the same requester stimulus, each with its own memory model.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_debugaccess, m1_debugaccess;

    logic        a_m0_waitrequest, a_m0_readdatavalid, a_m1_waitrequest, a_m1_readdatavalid;
    logic [31:0] a_m0_readdata, a_m1_readdata, a_mem_writedata, a_mem_readdata, a_rdq;
    logic [8:0]  a_mem_address;
    logic [3:0]  a_mem_byteenable;
    logic        a_mem_chipselect, a_mem_write, a_mem_debugaccess, a_mem_clken;
    logic        b_m0_waitrequest, b_m0_readdatavalid, b_m1_waitrequest, b_m1_readdatavalid;
    logic [31:0] b_m0_readdata, b_m1_readdata, b_mem_writedata, b_mem_readdata, b_rdq;
    logic [8:0]  b_mem_address;
    logic [3:0]  b_mem_byteenable;
    logic        b_mem_chipselect, b_mem_write, b_mem_debugaccess, b_mem_clken;
    logic [31:0] a_mem [512];
    logic [31:0] b_mem [512];

    int vec_cnt = 0;
    int miss_cnt = 0;
    logic [32:0] exp_q[$];

    typedef struct packed {
        logic rd0, wr0, rd1, wr1;
        logic [1:0] ga, gb;   // expected grant: 0 none, 1 m0, 2 m1
    } vec_t;
    vec_t tbl[14];

    onchip_mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(8), .PRIORITY_MODE(0)) u_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_debugaccess(m0_debugaccess),
        .m0_waitrequest(a_m0_waitrequest), .m0_readdata(a_m0_readdata),
        .m0_readdatavalid(a_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_debugaccess(m1_debugaccess),
        .m1_waitrequest(a_m1_waitrequest), .m1_readdata(a_m1_readdata),
        .m1_readdatavalid(a_m1_readdatavalid),
        .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
        .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
        .mem_writedata(a_mem_writedata), .mem_debugaccess(a_mem_debugaccess),
        .mem_clken(a_mem_clken), .mem_readdata(a_mem_readdata)
    );

    onchip_mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(8), .PRIORITY_MODE(1)) u_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_debugaccess(m0_debugaccess),
        .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
        .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_debugaccess(m1_debugaccess),
        .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
        .m1_readdatavalid(b_m1_readdatavalid),
        .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
        .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
        .mem_writedata(b_mem_writedata), .mem_debugaccess(b_mem_debugaccess),
        .mem_clken(b_mem_clken), .mem_readdata(b_mem_readdata)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    // Memory models: registered address, data out one cycle after a read.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 512; k++) a_mem[k] <= init_word(9'(k));
        end else if (a_mem_chipselect) begin
            if (a_mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (a_mem_byteenable[k]) a_mem[a_mem_address][8*k +: 8] <= a_mem_writedata[8*k +: 8];
            end else begin
                a_rdq <= a_mem[a_mem_address];
            end
        end
    end
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 512; k++) b_mem[k] <= init_word(9'(k));
        end else if (b_mem_chipselect) begin
            if (b_mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (b_mem_byteenable[k]) b_mem[b_mem_address][8*k +: 8] <= b_mem_writedata[8*k +: 8];
            end else begin
                b_rdq <= b_mem[b_mem_address];
            end
        end
    end
    assign a_mem_readdata = a_rdq;
    assign b_mem_readdata = b_rdq;

    // Driver tasks.
    task automatic set_idle();
        m0_address = '0; m1_address = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_writedata = '0; m1_writedata = '0;
        m0_debugaccess = 1'b0; m1_debugaccess = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {wait0, wait1, chipselect, mem_write, debugaccess, rdv0, rdv1, address}
    function automatic logic [15:0] tbl_exp(input logic [1:0] g, input logic w0, input logic w1,
                                            input logic rv0, input logic rv1);
        logic mw;
        mw = (g == 2'd1) ? w0 : (g == 2'd2) ? w1 : 1'b0;
        return {g != 2'd1, g != 2'd2, g != 2'd0, mw, g == 2'd2, rv0, rv1,
                (g == 2'd2) ? 9'h030 : 9'h020};
    endfunction

    // Scoreboard: compare this cycle's return against the oldest accepted read.
    task automatic sb_check();
        logic [32:0] e, got;
        logic vany;
        vany = a_m0_readdatavalid | a_m1_readdatavalid;
        got  = a_m1_readdatavalid ? {1'b1, a_m1_readdata} : {1'b0, a_m0_readdata};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_read_return", {a_m0_readdatavalid & a_m1_readdatavalid, vany, got},
                  {1'b0, 1'b1, e});
        end else begin
            check("sb_no_return", {31'd0, vany}, 32'd0);
        end
    endtask

    initial begin
        logic rva0, rva1, rvb0, rvb1;
        logic g;
        // rd0 wr0 rd1 wr1 ga gb
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};

        // Reset state.
        do_reset();
        #1;
        check("reset_outputs_a", {a_m0_waitrequest, a_m1_waitrequest, a_m0_readdatavalid,
              a_m1_readdatavalid, a_mem_chipselect, a_mem_write, a_mem_clken}, 7'b1100001);
        check("reset_outputs_b", {b_m0_waitrequest, b_m1_waitrequest, b_m0_readdatavalid,
              b_m1_readdatavalid, b_mem_chipselect, b_mem_write, b_mem_clken}, 7'b1100001);

        // Table-driven grant sequence from reset.
        do_reset();
        rva0 = 0; rva1 = 0; rvb0 = 0; rvb1 = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            m0_address = 9'h020; m1_address = 9'h030;
            m0_writedata = 32'h1111_1111; m1_writedata = 32'h2222_2222;
            m0_debugaccess = 1'b0; m1_debugaccess = 1'b1;
            m0_read = tbl[i].rd0; m0_write = tbl[i].wr0;
            m1_read = tbl[i].rd1; m1_write = tbl[i].wr1;
            #1;
            check($sformatf("tbl_a[%0d]", i),
                  {a_m0_waitrequest, a_m1_waitrequest, a_mem_chipselect, a_mem_write,
                   a_mem_debugaccess, a_m0_readdatavalid, a_m1_readdatavalid, a_mem_address},
                  tbl_exp(tbl[i].ga, tbl[i].wr0, tbl[i].wr1, rva0, rva1));
            check($sformatf("tbl_b[%0d]", i),
                  {b_m0_waitrequest, b_m1_waitrequest, b_mem_chipselect, b_mem_write,
                   b_mem_debugaccess, b_m0_readdatavalid, b_m1_readdatavalid, b_mem_address},
                  tbl_exp(tbl[i].gb, tbl[i].wr0, tbl[i].wr1, rvb0, rvb1));
            rva0 = (tbl[i].ga == 2'd1) & tbl[i].rd0 & ~tbl[i].wr0;
            rva1 = (tbl[i].ga == 2'd2) & tbl[i].rd1 & ~tbl[i].wr1;
            rvb0 = (tbl[i].gb == 2'd1) & tbl[i].rd0 & ~tbl[i].wr0;
            rvb1 = (tbl[i].gb == 2'd2) & tbl[i].rd1 & ~tbl[i].wr1;
        end

        // Single read after reset release.
        do_reset();
        @(negedge clk);
        m0_read = 1'b1; m0_address = 9'h010;
        #1;
        check("rd_accept_wait", {a_m0_waitrequest, b_m0_waitrequest}, 2'b00);
        @(negedge clk);
        set_idle();
        #1;
        check("rd_valid", {a_m0_readdatavalid, a_m1_readdatavalid}, 2'b10);
        check("rd_data", a_m0_readdata, 32'hC0DE_0010);

        // Partial write with debugaccess, then read it back.
        @(negedge clk);
        m0_write = 1'b1; m0_address = 9'h1A5; m0_writedata = 32'hDEAD_BEEF;
        m0_byteenable = 4'b0011; m0_debugaccess = 1'b1;
        #1;
        check("wr_mem_side", {a_mem_chipselect, a_mem_write, a_mem_byteenable, a_mem_debugaccess,
              a_mem_address, a_mem_writedata}, {1'b1, 1'b1, 4'b0011, 1'b1, 9'h1A5, 32'hDEAD_BEEF});
        @(negedge clk);
        m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'hF; m0_debugaccess = 1'b0;
        #1;
        check("wr_no_valid", {a_m0_readdatavalid, a_m1_readdatavalid}, 2'b00);
        @(negedge clk);
        set_idle();
        #1;
        check("wr_readback", {a_m0_readdatavalid, a_m0_readdata}, {1'b1, 32'hC0DE_BEEF});

        // Both streaming reads: blocks of 8, every read returned once in order.
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            m0_read = 1'b1; m1_read = 1'b1;
            m0_address = 9'(9'h040 + c); m1_address = 9'(9'h100 + c);
            #1;
            sb_check();
            g = ((c / 8) % 2) != 0;
            check($sformatf("rr_grant_a[%0d]", c), {a_m0_waitrequest, a_m1_waitrequest},
                  g ? 2'b10 : 2'b01);
            check($sformatf("rr_grant_b[%0d]", c), {b_m0_waitrequest, b_m1_waitrequest},
                  g ? 2'b10 : 2'b01);
            exp_q.push_back({g, init_word(g ? m1_address : m0_address)});
        end
        @(negedge clk);
        set_idle();
        #1;
        sb_check();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        // m1 streaming, m0 joins at beat 3: m1 keeps through beat 8.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            m1_read = 1'b1; m1_address = 9'(9'h080 + c);
            m0_read = (c >= 2 && c <= 10); m0_address = 9'h0C0;
            #1;
            g = (c < 8 || c > 10);
            check($sformatf("hold_b[%0d]", c), {b_m0_waitrequest, b_m1_waitrequest},
                  g ? 2'b10 : 2'b01);
            check($sformatf("hold_a[%0d]", c), {a_m0_waitrequest, a_m1_waitrequest},
                  g ? 2'b10 : 2'b01);
        end

        // m1 alone for 20 reads, then m0 joins: saturated hold yields at once.
        do_reset();
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            m1_read = 1'b1; m1_address = 9'(9'h140 + c);
            m0_read = (c == 20);
            #1;
            if (c == 20)
                check("sat_switch", {a_m0_waitrequest, a_m1_waitrequest,
                      b_m0_waitrequest, b_m1_waitrequest}, 4'b0101);
            else
                check($sformatf("solo_grant[%0d]", c), {a_m1_waitrequest, b_m1_waitrequest}, 2'b00);
            if (c > 0)
                check($sformatf("solo_ret[%0d]", c), {a_m1_readdatavalid, a_m1_readdata},
                      {1'b1, init_word(9'(9'h140 + c - 1))});
        end

        // Reset asserted in the cycle after an m1 read grant.
        do_reset();
        @(negedge clk);
        m1_read = 1'b1; m1_address = 9'h011;
        #1;
        check("mid_grant", a_m1_waitrequest, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_reset_a", {a_m0_waitrequest, a_m1_waitrequest, a_m0_readdatavalid,
              a_m1_readdatavalid, a_mem_chipselect, a_mem_write, a_mem_clken}, 7'b1100001);
        check("mid_reset_b", {b_m0_waitrequest, b_m1_waitrequest, b_m0_readdatavalid,
              b_m1_readdatavalid, b_mem_chipselect, b_mem_write, b_mem_clken}, 7'b1100001);
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("post_reset_valid[%0d]", c), {a_m0_readdatavalid, a_m1_readdatavalid,
                  b_m0_readdatavalid, b_m1_readdatavalid}, 4'b0000);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
